// File: rtl/pla_intb_vec_driver.sv
// PLA input driver: accepts a tagged 15-bit vector, holds it on the PLA
// inputs for two full cycles, captures the 7-bit PLA response on the second
// edge and queues {tag, z} in a small result FIFO.
module pla_intb_vec_driver #(
   parameter int unsigned DEPTH = 4,
   parameter int unsigned TAGW  = 8
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            in_valid,
   output logic            in_ready,
   input  logic [14:0]     in_vec,
   input  logic [TAGW-1:0] in_tag,
   output logic [14:0]     pla_x,
   input  logic [6:0]      pla_z,
   output logic            out_valid,
   input  logic            out_ready,
   output logic [6:0]      out_z,
   output logic [TAGW-1:0] out_tag,
   output logic [15:0]     vec_count,
   output logic            busy
);

   localparam int unsigned AW = $clog2(DEPTH);
   localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);

   typedef enum logic [1:0] {
      IDLE,
      SETTLE,
      CAPTURE
   } state_t;

   state_t            state_q;
   state_t            state_d;
   logic [TAGW-1:0]   tag_q;
   logic [TAGW+6:0]   mem [DEPTH];
   logic [AW-1:0]     wr_ptr;
   logic [AW-1:0]     rd_ptr;
   logic [AW:0]       count;
   logic [15:0]       vec_cnt_q;
   logic              accept;
   logic              push;
   logic              pop;

   // Ready only while idle with a free slot; gated by rst_n so it is low
   // throughout reset. The free slot checked here is the one the push uses.
   assign in_ready  = (state_q == IDLE) && (count < DEPTH_C) && rst_n;
   assign out_valid = (count != '0);
   assign pop       = out_valid & out_ready;
   assign busy      = (state_q != IDLE);
   assign vec_count = vec_cnt_q;
   assign out_z     = out_valid ? mem[rd_ptr][6:0]       : '0;
   assign out_tag   = out_valid ? mem[rd_ptr][TAGW+6:7]  : '0;

   // State register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= IDLE;
      else        state_q <= state_d;
   end

   // Next-state logic: accept in IDLE, one settle cycle, push on CAPTURE edge.
   always_comb begin
      state_d = state_q;
      accept  = 1'b0;
      push    = 1'b0;
      case (state_q)
         IDLE: begin
            accept = in_valid & in_ready;
            if (accept) state_d = SETTLE;
         end
         SETTLE:  state_d = CAPTURE;
         CAPTURE: begin
            push    = 1'b1;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   // Vector and tag are latched only at accept and held until the next one.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pla_x <= '0;
         tag_q <= '0;
      end else if (accept) begin
         pla_x <= in_vec;
         tag_q <= in_tag;
      end
   end

   // FIFO storage; contents are masked by out_valid so they need no reset.
   always_ff @(posedge clk) begin
      if (push) mem[wr_ptr] <= {tag_q, pla_z};
   end

   // FIFO pointers and occupancy; power-of-two depth lets pointers wrap naturally.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + AW'(1);
         if (pop)  rd_ptr <= rd_ptr + AW'(1);
         case ({push, pop})
            2'b10:   count <= count + (AW+1)'(1);
            2'b01:   count <= count - (AW+1)'(1);
            default: count <= count;
         endcase
      end
   end

   // Saturating count of results pushed since reset.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)                      vec_cnt_q <= '0;
      else if (push && vec_cnt_q != '1) vec_cnt_q <= vec_cnt_q + 16'd1;
   end

endmodule
